// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, S-box/Rcon lookups and key-expansion encodings
package aes_pkg;
  localparam int MAX_WORDS = 60;
  localparam logic [3:0] NK128 = 4'd4;
  localparam logic [3:0] NK192 = 4'd6;
  localparam logic [3:0] NK256 = 4'd8;
  localparam logic [3:0] NR_OFFSET = 4'd6;
  typedef enum logic {S_IDLE, S_EXPAND} state_e;
  localparam logic [0:127] RCON = 128'h01020408102040801b36_000000000000;
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction
  // rc counts from 1, so entry 1 sits at byte 0 of the table
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    return RCON[{idx - 4'd1, 3'b000} +: 8];
  endfunction
  function automatic logic nk_legal(input logic [3:0] nk);
    return nk == NK128 || nk == NK192 || nk == NK256;
  endfunction
endpackage

// File: rtl/sub_word.sv
// sub_word: combinational SubWord, four parallel S-box lookups
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
endmodule

// File: rtl/aes_key_expansion.sv
// aes_key_expansion: iterative AES-128/192/256 key schedule, one word per clock
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [0:3]                  Nk,
  input  logic [0:255]                key,
  output logic [0:(32*MAX_WORDS)-1]   w,
  output logic [0:3]                  Nr,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);
  state_e      state_q, state_d;
  logic [31:0] w_q [MAX_WORDS];
  logic [31:0] w_d [MAX_WORDS];
  logic [3:0]  nk_q, nk_d, nr_q, nr_d, rc_q, rc_d;
  logic [5:0]  i_q, i_d;
  logic [2:0]  j_q, j_d;
  logic        done_q, done_d, err_q, err_d;
  logic [31:0] prev, rot_in, sub_out, temp, new_word;
  logic        wrap;
  sub_word u_sub_word (.a(rot_in), .y(sub_out));
  // next schedule word from w[i-1] and w[i-Nk]; the S-box lane sees RotWord only at group start
  always_comb begin
    prev = w_q[i_q - 6'd1];
    rot_in = (j_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    temp = (j_q == 3'd0) ? sub_out ^ {rcon(rc_q), 24'h0} :
           (nk_q == NK256 && j_q == 3'd4) ? sub_out : prev;
    new_word = w_q[i_q - {2'b00, nk_q}] ^ temp;
    wrap = {1'b0, j_q} == nk_q - 4'd1;
  end
  // IDLE accepts a legal start and loads the key; EXPAND writes one word per cycle
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    nk_d = nk_q;
    nr_d = nr_q;
    i_d = i_q;
    j_d = j_q;
    rc_d = rc_q;
    done_d = done_q;
    err_d = 1'b0;
    if (state_q == S_IDLE) begin
      err_d = start && !nk_legal(Nk);
      if (start && nk_legal(Nk)) begin
        for (int k = 0; k < MAX_WORDS; k++) w_d[k] = '0;
        for (int k = 0; k < 8; k++) if (4'(k) < Nk) w_d[k] = key[32*k +: 32];
        state_d = S_EXPAND;
        nk_d = Nk;
        nr_d = Nk + NR_OFFSET;
        i_d = {2'b00, Nk};
        j_d = 3'd0;
        rc_d = 4'd1;
        done_d = 1'b0;
      end
    end else begin
      w_d[i_q] = new_word;
      i_d = i_q + 6'd1;
      j_d = wrap ? 3'd0 : j_q + 3'd1;
      rc_d = rc_q + {3'b000, wrap};
      state_d = (i_q == {nr_q, 2'b11}) ? S_IDLE : S_EXPAND;
      done_d = i_q == {nr_q, 2'b11};
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q <= '{default: '0};
      nk_q <= '0;
      nr_q <= '0;
      i_q <= '0;
      j_q <= '0;
      rc_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      nk_q <= nk_d;
      nr_q <= nr_d;
      i_q <= i_d;
      j_q <= j_d;
      rc_q <= rc_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  genvar g;
  for (g = 0; g < MAX_WORDS; g++) begin : g_w
    assign w[32*g +: 32] = w_q[g];
  end
  assign Nr = nr_q;
  assign busy = state_q == S_EXPAND;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_aes_key_expansion.sv
// tb_aes_key_expansion: randomized and FIPS-197 checks against a GF(2^8) reference model
module tb_aes_key_expansion;
  logic           clk = 1'b0;
  logic           rst, start;
  logic [0:3]     Nk;
  logic [0:255]   key;
  logic [0:1919]  w;
  logic [0:3]     Nr;
  logic           busy, done, err;
  int             checks = 0;
  int             failures = 0;
  logic [31:0]    exp_w [60];
  logic [7:0]     sb [256];
  logic [0:255]   k_r;
  logic [0:1919]  w_save;
  logic [127:0]   ct;

  always #5 clk = ~clk;

  aes_key_expansion dut (
    .clk(clk), .rst(rst), .start(start), .Nk(Nk), .key(key),
    .w(w), .Nr(Nr), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
              {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic model(input logic [0:255] k, input int nk);
    logic [31:0] t;
    logic [7:0] rc;
    for (int i = 0; i < 60; i++) exp_w[i] = 32'h0;
    for (int i = 0; i < nk; i++) exp_w[i] = k[32*i +: 32];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = exp_w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) t = subw(t);
      exp_w[i] = exp_w[i-nk] ^ t;
    end
  endtask

  task automatic rand_key(output logic [0:255] k);
    for (int q = 0; q < 8; q++) k[32*q +: 32] = $urandom();
  endtask

  task automatic run(input string name, input logic [0:255] k, input int nk, input bit disturb);
    int n;
    model(k, nk);
    start = 1'b1;
    Nk = 4'(nk);
    key = k;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_on"}, 64'(busy), 64'd1);
    chk({name, "_done_clr"}, 64'(done), 64'd0);
    n = 0;
    while (!done && n < 200) begin
      start = disturb && n == 10;
      if (start) begin
        key = ~k;
        Nk = 4'd4;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({name, "_latency"}, 64'(n), 64'(4 * (nk + 7) - nk));
    chk({name, "_busy_off"}, 64'(busy), 64'd0);
    chk({name, "_nr"}, 64'(Nr), 64'(nk + 6));
    for (int i = 0; i < 60; i++)
      chk($sformatf("%s_w%0d", name, i), 64'(w[32*i +: 32]), 64'(exp_w[i]));
  endtask

  function automatic logic [7:0] rkb(input int r, input int k);
    logic [31:0] wd;
    wd = w[32*(4*r + k/4) +: 32];
    return wd[31-8*(k%4) -: 8];
  endfunction

  task automatic cipher(input logic [127:0] pt, output logic [127:0] c);
    logic [7:0] s [16];
    logic [7:0] t [16];
    int nr;
    nr = int'(Nr);
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rkb(0, k);
    for (int r = 1; r <= nr; r++) begin
      for (int rr = 0; rr < 4; rr++)
        for (int cc = 0; cc < 4; cc++) t[rr+4*cc] = sb[s[rr+4*((cc+rr)%4)]];
      if (r < nr) begin
        for (int cc = 0; cc < 4; cc++) begin
          s[4*cc]   = gm(t[4*cc], 2) ^ gm(t[4*cc+1], 3) ^ t[4*cc+2] ^ t[4*cc+3];
          s[4*cc+1] = t[4*cc] ^ gm(t[4*cc+1], 2) ^ gm(t[4*cc+2], 3) ^ t[4*cc+3];
          s[4*cc+2] = t[4*cc] ^ t[4*cc+1] ^ gm(t[4*cc+2], 2) ^ gm(t[4*cc+3], 3);
          s[4*cc+3] = gm(t[4*cc], 3) ^ t[4*cc+1] ^ t[4*cc+2] ^ gm(t[4*cc+3], 2);
        end
      end else s = t;
      for (int k = 0; k < 16; k++) s[k] ^= rkb(r, k);
    end
    for (int k = 0; k < 16; k++) c[127-8*k -: 8] = s[k];
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_w_zero"}, 64'(w != '0), 64'd0);
    chk({name, "_nr"}, 64'(Nr), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    build_sbox();
    rst = 1'b1;
    start = 1'b1;
    Nk = 4'd4;
    rand_key(k_r);
    key = k_r;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    run("a1", {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 1'b0);
    chk("a1_w4", 64'(w[32*4 +: 32]), 64'h a0fafe17);
    chk("a1_w43", 64'(w[32*43 +: 32]), 64'h b6630ca6);
    chk("a1_w44_59_zero", 64'(w[32*44 +: 512] != '0), 64'd0);
    cipher(128'h3243f6a8885a308d313198a2e0370734, ct);
    chk("a1_cipher_hi", 64'(ct[127:64]), 64'h3925841d02dc09fb);
    chk("a1_cipher_lo", 64'(ct[63:0]), 64'hdc118597196a0b32);

    w_save = w;
    foreach (k_r[q]) if (q < 3) begin
      start = 1'b1;
      Nk = (q == 0) ? 4'd5 : (q == 1) ? 4'd0 : 4'd7;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("err_pulse_%0d", q), 64'(err), 64'd1);
      chk($sformatf("err_busy_%0d", q), 64'(busy), 64'd0);
      chk($sformatf("err_done_%0d", q), 64'(done), 64'd1);
      chk($sformatf("err_w_kept_%0d", q), 64'(w != w_save), 64'd0);
      @(negedge clk);
      chk($sformatf("err_clear_%0d", q), 64'(err), 64'd0);
    end

    run("a2", {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 6, 1'b0);
    chk("a2_w6", 64'(w[32*6 +: 32]), 64'h fe0c91f7);
    chk("a2_w51", 64'(w[32*51 +: 32]), 64'h 01002202);
    run("a3", 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 8, 1'b0);
    chk("a3_w8", 64'(w[32*8 +: 32]), 64'h 9ba35411);
    chk("a3_w59", 64'(w[32*59 +: 32]), 64'h 706c631e);

    rand_key(k_r);
    run("busy_start", k_r, 6, 1'b1);
    for (int r = 0; r < 6; r++) begin
      rand_key(k_r);
      run($sformatf("rnd%0d", r), k_r, 4 + 2 * int'($urandom_range(0, 2)), 1'b0);
    end

    rand_key(k_r);
    start = 1'b1;
    Nk = 4'd8;
    key = k_r;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("mid_rst");
    rand_key(k_r);
    run("post_rst", k_r, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
